// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and sizing helper for the PISO serializer
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width: enough to hold WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer with valid/ready load and gapless reload
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt;
    logic             last_tick;
    logic             accept;
    logic             done_q;

    // The tick that consumes the final bit; also the only SHIFT-state reload window.
    assign last_tick = (state == SHIFT) && shift_en && (cnt == LAST_CNT);

    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        state_n    = state;
        load_ready = !rst && !abort && ((state == IDLE) || last_tick);
        accept     = load_valid && load_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (last_tick && !accept) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A tick coinciding with an accept belongs to the outgoing word, never the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_tick && !abort;
            if (accept) begin
                shreg <= load_data;
                cnt   <= '0;
            end else if ((state == SHIFT) && shift_en && !abort && !last_tick) begin
                shreg <= shreg_shifted;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    assign sout       = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed table-driven bench for piso_serializer (MSB- and LSB-first)
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b0;
    logic       abort = 1'b0;

    logic ready_m, sout_m, valid_m, busy_m, done_m;
    logic ready_l, sout_l, valid_l, busy_l, done_l;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       lv;
        logic [7:0] data;
        logic       se;
        logic       ab;
        logic       rdy;
        logic       sm;
        logic       sl;
        logic       vld;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
        .load_data(load_data), .shift_en(shift_en), .abort(abort),
        .sout(sout_m), .sout_valid(valid_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
        .load_data(load_data), .shift_en(shift_en), .abort(abort),
        .sout(sout_l), .sout_valid(valid_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic lv, input logic [7:0] d, input logic se, input logic ab,
                       input logic rdy, input logic sm, input logic sl, input logic vld,
                       input logic dn);
        vec_t v;
        v.lv = lv; v.data = d; v.se = se; v.ab = ab; v.rdy = rdy;
        v.sm = sm; v.sl = sl; v.vld = vld; v.dn = dn;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic lv, input logic [7:0] d, input logic se, input logic ab);
        load_valid = lv;
        load_data  = d;
        shift_en   = se;
        abort      = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [7:0] w;

        // 0xC1: one word, MSB 1,1,0,0,0,0,0,1 / LSB 1,0,0,0,0,0,1,1
        w = 8'hC1;
        for (int k = 0; k < 8; k++)
            add(k == 0, w, 1'b1, 1'b0, k == 0, w[7-k], w[k], 1'b1, 1'b0);
        add(1'b0, w, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, w, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // 0xFF then 0x00 back-to-back with load_valid held
        for (int j = 0; j < 8; j++)
            add(1'b1, (j == 0) ? 8'hFF : 8'h00, 1'b1, 1'b0, j == 0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 7; j++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // abort in IDLE: masks load_ready, otherwise no effect
        add(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset state
        #1;
        chk("rst sout", sout_m, 1'b0);
        chk("rst sout_valid", valid_m, 1'b0);
        chk("rst busy", busy_m, 1'b0);
        chk("rst done", done_m, 1'b0);
        chk("rst load_ready", ready_m, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].lv, vecs[i].data, vecs[i].se, vecs[i].ab);
            #1;
            chk($sformatf("row%0d load_ready_m", i), ready_m, vecs[i].rdy);
            chk($sformatf("row%0d load_ready_l", i), ready_l, vecs[i].rdy);
            tick();
            chk($sformatf("row%0d sout_m", i), sout_m, vecs[i].sm);
            chk($sformatf("row%0d sout_l", i), sout_l, vecs[i].sl);
            chk($sformatf("row%0d sout_valid", i), valid_m, vecs[i].vld);
            chk($sformatf("row%0d busy", i), busy_m, vecs[i].vld);
            chk($sformatf("row%0d done_m", i), done_m, vecs[i].dn);
            chk($sformatf("row%0d done_l", i), done_l, vecs[i].dn);
        end

        // shift_en every 3rd cycle, 0x81: each bit held 3 cycles, done after 24
        w = 8'h81;
        drive(1'b1, w, 1'b0, 1'b0);
        tick();
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) begin
                drive(1'b0, w, (k % 3) == 0, 1'b0);
                tick();
            end
            if (k < 24) begin
                chk($sformatf("slow k%0d sout_m", k), sout_m, w[7-k/3]);
                chk($sformatf("slow k%0d sout_l", k), sout_l, w[k/3]);
                chk($sformatf("slow k%0d done", k), done_m, 1'b0);
                chk($sformatf("slow k%0d busy", k), busy_m, 1'b1);
            end else begin
                chk("slow done", done_m, 1'b1);
                chk("slow busy", busy_m, 1'b0);
                chk("slow sout idle", sout_m, 1'b0);
            end
        end

        // abort at cnt=3 with load_valid high
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        repeat (3) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("abort pre busy", busy_m, 1'b1);
        drive(1'b1, 8'h3C, 1'b1, 1'b1);
        #1;
        chk("abort load_ready", ready_m, 1'b0);
        tick();
        chk("abort busy", busy_m, 1'b0);
        chk("abort sout", sout_m, 1'b0);
        chk("abort sout_valid", valid_m, 1'b0);
        chk("abort done", done_m, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("abort after done", done_m, 1'b0);
        chk("abort after busy", busy_m, 1'b0);

        // async reset at cnt=5
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        repeat (5) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("rstmid pre sout", sout_m, 1'b1);
        chk("rstmid pre busy", busy_m, 1'b1);
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid sout_m", sout_m, 1'b0);
        chk("rstmid sout_l", sout_l, 1'b0);
        chk("rstmid busy", busy_m, 1'b0);
        chk("rstmid sout_valid", valid_m, 1'b0);
        chk("rstmid load_ready", ready_m, 1'b0);
        chk("rstmid done", done_m, 1'b0);
        tick();
        tick();
        chk("rsthold load_ready", ready_m, 1'b0);
        chk("rsthold busy", busy_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("rstrel load_ready", ready_m, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("rstrel busy", busy_m, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
